// File: rtl/drac_pkg.sv
// Shared types and constants for the IR-stage issue scheduler.
package drac_pkg;

  localparam int NUM_REGS        = 32;
  localparam int IR_MAX_INFLIGHT = 15;

  typedef enum logic [1:0] {
    IR_RUN     = 2'd0,
    IR_DRAIN   = 2'd1,
    IR_RECOVER = 2'd2
  } ir_sched_state_t;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_MEM = 2'd2,
    UNIT_BR  = 2'd3
  } unit_class_t;

  // Number of set bits in a two-lane vector.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/ir_busy_scoreboard.sv
// Per-register busy scoreboard: two set ports (issue), two clear ports
// (writeback), a global flush clear and six combinational lookups.
// Register x0 is hard-wired not busy. A set beats a clear of the same
// register in one cycle; clears become visible the following cycle.
module ir_busy_scoreboard
  import drac_pkg::*;
#(
  parameter int NREGS = NUM_REGS
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic [1:0]      set_en_i,
  input  logic [1:0][4:0] set_rd_i,
  input  logic [1:0]      clr_en_i,
  input  logic [1:0][4:0] clr_rd_i,
  input  logic [5:0][4:0] lk_reg_i,
  output logic [5:0]      lk_busy_o,
  output logic            any_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  genvar gi;

  // Next-state per register: flush clears everything, otherwise set wins over clear.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_xn
        logic set_hit;
        logic clr_hit;
        assign set_hit = (set_en_i[0] && (set_rd_i[0] == 5'(gi))) ||
                         (set_en_i[1] && (set_rd_i[1] == 5'(gi)));
        assign clr_hit = (clr_en_i[0] && (clr_rd_i[0] == 5'(gi))) ||
                         (clr_en_i[1] && (clr_rd_i[1] == 5'(gi)));
        assign busy_d[gi] = ~flush_i & (set_hit | (busy_q[gi] & ~clr_hit));
      end
    end
  endgenerate

  // Lookups read the registered bits only, so there is no same-cycle bypass.
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lookup
      assign lk_busy_o[gi] = busy_q[lk_reg_i[gi]];
    end
  endgenerate

  assign any_busy_o = |busy_q;

  // Busy bit storage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ir_issue_scheduler.sv
// IR-stage issue scheduler: decides each cycle whether the oldest one or two
// instruction-queue head entries are popped and issued.
// Build option: define IR_DUAL_ISSUE_EN for dual issue; without it only
// slot0 can issue and the slot1 hazard logic is not built.
module ir_issue_scheduler
  import drac_pkg::*;
#(
  parameter int IQ_ENTRIES   = 8,
  parameter int NUM_REGS     = drac_pkg::NUM_REGS,
  parameter int MAX_INFLIGHT = IR_MAX_INFLIGHT
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        flush_i,
  input  logic [$clog2(IQ_ENTRIES):0] iq_count_i,
  input  logic [1:0]                  slot_valid_i,
  input  logic [1:0][4:0]             slot_rs1_i,
  input  logic [1:0][4:0]             slot_rs2_i,
  input  logic [1:0][4:0]             slot_rd_i,
  input  logic [1:0]                  slot_rd_we_i,
  input  logic [1:0][1:0]             slot_unit_i,
  input  logic [1:0]                  slot_serial_i,
  input  logic [1:0]                  exe_ready_i,
  input  logic [1:0]                  wb_valid_i,
  input  logic [1:0][4:0]             wb_rd_i,
  input  logic [1:0]                  retire_i,
  output logic [1:0]                  read_head_o,
  output logic [1:0]                  issue_o,
  output logic [1:0]                  state_o,
  output logic [3:0]                  inflight_o
);

  localparam int CW = $clog2(IQ_ENTRIES) + 1;

  localparam logic [1:0] ST_RUN     = IR_RUN;
  localparam logic [1:0] ST_DRAIN   = IR_DRAIN;
  localparam logic [1:0] ST_RECOVER = IR_RECOVER;

  localparam logic [3:0] INFL_MAX = 4'(MAX_INFLIGHT);

  logic [1:0]      state_q, state_d;
  logic [3:0]      inflight_q, inflight_d;
  logic [1:0]      issue;
  logic [1:0]      set_en;
  logic [5:0][4:0] lk_reg;
  logic [5:0]      lk_busy;
  logic            any_busy;
  logic            can_issue;
  logic            haz0;
  logic            serial_ok0;
  logic [4:0]      inc_sum;
  logic [1:0]      n_ret;
  logic            underflow;

  // Lookup order: slot0 rs1, rs2, rd, then slot1 rs1, rs2, rd.
  assign lk_reg = {slot_rd_i[1], slot_rs2_i[1], slot_rs1_i[1],
                   slot_rd_i[0], slot_rs2_i[0], slot_rs1_i[0]};

  ir_busy_scoreboard #(
    .NREGS (NUM_REGS)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .flush_i    (flush_i),
    .set_en_i   (set_en),
    .set_rd_i   (slot_rd_i),
    .clr_en_i   (wb_valid_i),
    .clr_rd_i   (wb_rd_i),
    .lk_reg_i   (lk_reg),
    .lk_busy_o  (lk_busy),
    .any_busy_o (any_busy)
  );

  // Issue is only possible in RUN, outside reset and flush.
  assign can_issue  = rstn_i & ~flush_i & (state_q == ST_RUN);
  // WAW is only a hazard when the entry actually writes rd.
  assign haz0       = lk_busy[0] | lk_busy[1] | (slot_rd_we_i[0] & lk_busy[2]);
  assign serial_ok0 = ~slot_serial_i[0] | ((inflight_q == 4'd0) & ~any_busy);

  assign issue[0] = can_issue & (iq_count_i != '0) & slot_valid_i[0] & exe_ready_i[0] &
                    (inflight_q < INFL_MAX) & ~haz0 & serial_ok0;

`ifdef IR_DUAL_ISSUE_EN
  localparam logic [1:0]    U_MUL       = UNIT_MUL;
  localparam logic [1:0]    U_MEM       = UNIT_MEM;
  localparam logic [3:0]    INFL_MAX_M2 = 4'(MAX_INFLIGHT - 2);
  localparam logic [CW-1:0] CNT_TWO     = CW'(2);

  logic haz1;
  logic pair_dep;
  logic pair_struct;

  assign haz1        = lk_busy[3] | lk_busy[4] | (slot_rd_we_i[1] & lk_busy[5]);
  // slot1 must not consume or overwrite the register slot0 produces this cycle.
  assign pair_dep    = slot_rd_we_i[0] && (slot_rd_i[0] != 5'd0) &&
                       ((slot_rs1_i[1] == slot_rd_i[0]) || (slot_rs2_i[1] == slot_rd_i[0]) ||
                        (slot_rd_we_i[1] && (slot_rd_i[1] == slot_rd_i[0])));
  // Only one memory port and one multiplier in the backend.
  assign pair_struct = ((slot_unit_i[0] == U_MEM) && (slot_unit_i[1] == U_MEM)) ||
                       ((slot_unit_i[0] == U_MUL) && (slot_unit_i[1] == U_MUL));

  assign issue[1] = issue[0] & (iq_count_i >= CNT_TWO) & slot_valid_i[1] & exe_ready_i[1] &
                    (inflight_q <= INFL_MAX_M2) & ~haz1 & ~slot_serial_i[0] &
                    ~slot_serial_i[1] & ~pair_dep & ~pair_struct;
`else
  logic unused_slot1;
  assign unused_slot1 = ^{lk_busy[5:3], slot_valid_i[1], exe_ready_i[1],
                          slot_serial_i[1], slot_unit_i};
  assign issue[1] = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_set
      assign set_en[gi] = issue[gi] & slot_rd_we_i[gi] & (slot_rd_i[gi] != 5'd0);
    end
  endgenerate

  // In-flight counter next value, clamped at zero on an over-retire.
  always_comb begin
    n_ret      = popcount2(retire_i);
    inc_sum    = {1'b0, inflight_q} + {3'b000, popcount2(issue)};
    underflow  = inc_sum < {3'b000, n_ret};
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = 4'd0;
    end else if (underflow) begin
      inflight_d = 4'd0;
    end else begin
      inflight_d = 4'(inc_sum - {3'b000, n_ret});
    end
  end

  // Scheduler FSM: drain before a serialising head, one recovery cycle after flush.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RECOVER;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (slot_valid_i[0] && slot_serial_i[0] && ((inflight_q != 4'd0) || any_busy)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_q == 4'd0) && !any_busy) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and in-flight registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_RUN;
      inflight_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  retire_underflow_a : assert property (@(posedge clk_i) disable iff (!rstn_i)
                                        !(underflow && !flush_i));

  assign issue_o     = issue;
  assign read_head_o = issue;
  assign state_o     = state_q;
  assign inflight_o  = inflight_q;

endmodule

// File: tb/tb_ir_issue_scheduler.sv
// Randomised self-checking bench for ir_issue_scheduler with a behavioural
// reference model, plus directed scenarios for the key issue cases.
module tb_ir_issue_scheduler;

`ifdef IR_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush;
  logic [3:0]      iq_count;
  logic [1:0]      slot_valid;
  logic [1:0][4:0] rs1, rs2, rd;
  logic [1:0]      we;
  logic [1:0][1:0] unit;
  logic [1:0]      serial;
  logic [1:0]      ready;
  logic [1:0]      wb_valid;
  logic [1:0][4:0] wb_rd;
  logic [1:0]      retire;
  logic [1:0]      read_head_o, issue_o, state_o;
  logic [3:0]      inflight_o;

  ir_issue_scheduler dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .flush_i       (flush),
    .iq_count_i    (iq_count),
    .slot_valid_i  (slot_valid),
    .slot_rs1_i    (rs1),
    .slot_rs2_i    (rs2),
    .slot_rd_i     (rd),
    .slot_rd_we_i  (we),
    .slot_unit_i   (unit),
    .slot_serial_i (serial),
    .exe_ready_i   (ready),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .retire_i      (retire),
    .read_head_o   (read_head_o),
    .issue_o       (issue_o),
    .state_o       (state_o),
    .inflight_o    (inflight_o)
  );

  always #5 clk = ~clk;

  // Reference model state: busy flags, in-flight count, state (0 RUN, 1 DRAIN, 2 RECOVER).
  bit   m_busy[32];
  int   m_infl;
  int   m_st;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [1:0] last_issue;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bz(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    m_infl = 0;
    m_st   = 0;
  endtask

  task automatic idle();
    flush = 0; iq_count = 0; slot_valid = 0; rs1 = '0; rs2 = '0; rd = '0;
    we = 0; unit = '0; serial = 0; ready = 2'b11; wb_valid = 0; wb_rd = '0; retire = 0;
  endtask

  task automatic set_slot(input int i, input int r1, input int r2, input int d,
                          input bit w, input int u, input bit s);
    rs1[i] = 5'(r1); rs2[i] = 5'(r2); rd[i] = 5'(d);
    we[i] = w; unit[i] = 2'(u); serial[i] = s; slot_valid[i] = 1'b1;
  endtask

  // One clock: called just after a falling edge with inputs applied; checks
  // the DUT against the model, advances the model, and waits for the next falling edge.
  task automatic run_cycle();
    bit any, run, e0, e1;
    int ni, nr;
    #1;
    any = 0;
    for (int r = 1; r < 32; r++) any |= m_busy[r];
    run = (m_st == 0) && !flush;
    e0 = run && (iq_count >= 1) && slot_valid[0] && ready[0] && (m_infl < 15) &&
         !bz(rs1[0]) && !bz(rs2[0]) && !(we[0] && bz(rd[0])) &&
         (!serial[0] || (m_infl == 0 && !any));
    e1 = DUAL && e0 && (iq_count >= 2) && slot_valid[1] && ready[1] && (m_infl <= 13) &&
         !bz(rs1[1]) && !bz(rs2[1]) && !(we[1] && bz(rd[1])) &&
         !serial[0] && !serial[1] &&
         !(we[0] && rd[0] != 0 && (rs1[1] == rd[0] || rs2[1] == rd[0] || (we[1] && rd[1] == rd[0]))) &&
         !(unit[0] == 2 && unit[1] == 2) && !(unit[0] == 1 && unit[1] == 1);
    last_issue = issue_o;
    check_eq("issue", 32'(issue_o), 32'({e1, e0}));
    check_eq("read_head", 32'(read_head_o), 32'({e1, e0}));
    check_eq("state", 32'(state_o), 32'(m_st));
    check_eq("inflight", 32'(inflight_o), 32'(m_infl));
    $display("[TB] cyc=%0d flush=%0b cnt=%0d iss=%b st=%0d infl=%0d", cyc, flush, iq_count,
             issue_o, state_o, inflight_o);
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_infl = 0;
      m_st   = 2;
    end else begin
      case (m_st)
        0: if (slot_valid[0] && serial[0] && (m_infl != 0 || any)) m_st = 1;
        1: if (m_infl == 0 && !any) m_st = 0;
        default: m_st = 0;
      endcase
      for (int l = 0; l < 2; l++) if (wb_valid[l]) m_busy[wb_rd[l]] = 1'b0;
      if (e0 && we[0] && rd[0] != 0) m_busy[rd[0]] = 1'b1;
      if (e1 && we[1] && rd[1] != 0) m_busy[rd[1]] = 1'b1;
      ni = int'(e0) + int'(e1);
      nr = int'(retire[0]) + int'(retire[1]);
      m_infl = m_infl + ni - nr;
      if (m_infl < 0) m_infl = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle();
    rstn = 1'b0;
    iq_count = 2; slot_valid = 2'b11;
    #12;
    check_eq("rst_issue", 32'(issue_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_inflight", 32'(inflight_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle();

    // Independent ADD x1 / ADD x2.
    iq_count = 2;
    set_slot(0, 0, 0, 1, 1, 0, 0);
    set_slot(1, 0, 0, 2, 1, 0, 0);
    run_cycle();
    check_eq("t1_issue", 32'(last_issue), DUAL ? 32'd3 : 32'd1);
    check_eq("t1_inflight", 32'(inflight_o), DUAL ? 32'd2 : 32'd1);
    if (DUAL) begin
      idle(); iq_count = 1; set_slot(0, 1, 0, 3, 1, 0, 0);   // reads busy x1
      run_cycle();
      check_eq("t1_raw_x1", 32'(last_issue), 32'd0);
    end else begin
      idle(); iq_count = 1; set_slot(0, 0, 0, 2, 1, 0, 0);   // ADD x2 now at head
      run_cycle();
      check_eq("t6_second", 32'(last_issue), 32'd1);
    end
    idle(); retire = 2'b11; wb_valid = 2'b11; wb_rd[0] = 5'd1; wb_rd[1] = 5'd2;
    run_cycle();
    check_eq("t1_drained", 32'(inflight_o), 32'd0);

    // slot0 writes x5, slot1 reads x5.
    idle(); iq_count = 2;
    set_slot(0, 0, 0, 5, 1, 0, 0);
    set_slot(1, 5, 0, 6, 1, 0, 0);
    run_cycle();
    check_eq("t2_issue", 32'(last_issue), 32'd1);
    idle(); iq_count = 1; set_slot(0, 5, 0, 6, 1, 0, 0);
    run_cycle();
    check_eq("t2_stall", 32'(last_issue), 32'd0);
    wb_valid = 2'b01; wb_rd[0] = 5'd5;
    run_cycle();
    check_eq("t2_nobypass", 32'(last_issue), 32'd0);
    wb_valid = 2'b00;
    run_cycle();
    check_eq("t2_release", 32'(last_issue), 32'd1);
    idle(); retire = 2'b11; wb_valid = 2'b01; wb_rd[0] = 5'd6;
    run_cycle();

    // Both MEM: only slot0.
    idle(); iq_count = 2;
    set_slot(0, 0, 0, 0, 0, 2, 0);
    set_slot(1, 0, 0, 0, 0, 2, 0);
    run_cycle();
    check_eq("t3_mem", 32'(last_issue), 32'd1);
    iq_count = 2; set_slot(1, 0, 0, 0, 0, 0, 0);
    run_cycle();
    // Fill to three in flight, then present a fence.
    idle(); iq_count = 1; set_slot(0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check_eq("t4_pre_infl", 32'(inflight_o), DUAL ? 32'd4 : 32'd3);
    idle(); retire = DUAL ? 2'b01 : 2'b00; iq_count = 1; set_slot(0, 0, 0, 0, 0, 0, 1);
    run_cycle();
    check_eq("t4_fence_blocked", 32'(last_issue), 32'd0);
    check_eq("t4_drain", 32'(state_o), 32'd1);
    retire = 2'b11; run_cycle();
    retire = 2'b01; run_cycle();
    retire = 2'b00; run_cycle();
    check_eq("t4_run", 32'(state_o), 32'd0);
    run_cycle();
    check_eq("t4_fence_issue", 32'(last_issue), 32'd1);
    idle(); retire = 2'b01; run_cycle();

    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      idle();
      flush    = ($urandom_range(0, 39) == 0);
      iq_count = 4'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        slot_valid[i] = ($urandom_range(0, 7) != 0);
        rs1[i]    = 5'($urandom_range(0, 7));
        rs2[i]    = 5'($urandom_range(0, 7));
        rd[i]     = 5'($urandom_range(0, 7));
        we[i]     = ($urandom_range(0, 3) != 0);
        unit[i]   = 2'($urandom_range(0, 3));
        serial[i] = ($urandom_range(0, 9) == 0);
        ready[i]  = ($urandom_range(0, 7) != 0);
        wb_valid[i] = $urandom_range(0, 1) == 1;
        wb_rd[i]  = 5'($urandom_range(0, 7));
        retire[i] = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      end
      if (int'(retire[0]) + int'(retire[1]) > m_infl) retire = (m_infl == 1) ? 2'b01 : 2'b00;
      run_cycle();
    end

    // Flush with in-flight work and busy registers.
    idle(); iq_count = 2;
    set_slot(0, 0, 0, 9, 1, 0, 0);
    set_slot(1, 0, 0, 10, 1, 1, 0);
    run_cycle();
    flush = 1; wb_valid = 2'b01; wb_rd[0] = 5'd9; retire = 2'b00;
    run_cycle();
    check_eq("t5_flush_issue", 32'(last_issue), 32'd0);
    check_eq("t5_recover", 32'(state_o), 32'd2);
    check_eq("t5_infl", 32'(inflight_o), 32'd0);
    flush = 0; wb_valid = 0; iq_count = 1; set_slot(0, 9, 10, 11, 1, 0, 0);
    run_cycle();
    check_eq("t5_recover_noissue", 32'(last_issue), 32'd0);
    check_eq("t5_run", 32'(state_o), 32'd0);
    run_cycle();
    check_eq("t5_sb_clear", 32'(last_issue), 32'd1);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_state", 32'(state_o), 32'd0);
    check_eq("arst_infl", 32'(inflight_o), 32'd0);
    check_eq("arst_issue", 32'(issue_o), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(); iq_count = 1; set_slot(0, 11, 0, 12, 1, 0, 0);
    run_cycle();
    check_eq("arst_sb_clear", 32'(last_issue), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
